// File: rtl/vector_lane_sequencer.sv
// Multi-beat vector ALU: LANES elements per cycle, valid/ready in and out.
// Optional VECTOR_LANE_SEQUENCER_SATURATE_EN makes add/sub signed-saturating.
module vector_lane_sequencer #(
  parameter int DATA_WIDTH        = 16,
  parameter int VECTOR_SIZE       = 6,
  parameter int LANES             = 2,
  parameter int ALU_CONTROL_WIDTH = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ALU_CONTROL_WIDTH-1:0]      in_alu_control,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] in_operand1,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] in_operand2,
  input  logic [DATA_WIDTH-1:0]             in_scalar,
  input  logic                              in_vector_scalar,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] out_result,
  output logic                              busy
);

  localparam int BEATS   = (VECTOR_SIZE + LANES - 1) / LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SHIFT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int VW      = VECTOR_SIZE * DATA_WIDTH;
  localparam int ACW     = ALU_CONTROL_WIDTH;

  localparam logic [ACW-1:0] OP_ADD = ACW'(0);
  localparam logic [ACW-1:0] OP_SUB = ACW'(1);
  localparam logic [ACW-1:0] OP_AND = ACW'(2);
  localparam logic [ACW-1:0] OP_OR  = ACW'(3);
  localparam logic [ACW-1:0] OP_XOR = ACW'(4);
  localparam logic [ACW-1:0] OP_SLL = ACW'(5);
  localparam logic [ACW-1:0] OP_SRL = ACW'(6);
  localparam logic [ACW-1:0] OP_MUL = ACW'(7);

  typedef logic [DATA_WIDTH-1:0] elem_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            stateNext;
  logic [VW-1:0]     opA;
  logic [VW-1:0]     opB;
  logic [VW-1:0]     result;
  logic [ACW-1:0]    ctrl;
  logic [BEAT_W-1:0] beat;
  logic              accept;
  logic              lastBeat;

  assign accept   = in_valid && in_ready;
  assign lastBeat = (beat == BEAT_W'(BEATS - 1));

`ifdef VECTOR_LANE_SEQUENCER_SATURATE_EN
  // Sign bit and carry disagree only on signed overflow.
  function automatic elem_t satClamp(input logic [DATA_WIDTH:0] w);
    if (w[DATA_WIDTH] != w[DATA_WIDTH-1])
      return w[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return w[DATA_WIDTH-1:0];
  endfunction
`endif

  function automatic elem_t aluOp(
    input logic [ACW-1:0] op,
    input elem_t          a,
    input elem_t          b
  );
    elem_t r;
    r = '0;
    case (op)
`ifdef VECTOR_LANE_SEQUENCER_SATURATE_EN
      OP_ADD: r = satClamp({a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b});
      OP_SUB: r = satClamp({a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b});
`else
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
`endif
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SLL: r = a << b[SHIFT_W-1:0];
      OP_SRL: r = a >> b[SHIFT_W-1:0];
      OP_MUL: r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = RUN;
      RUN:  if (lastBeat) stateNext = DONE;
      DONE: if (out_ready) stateNext = accept ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opA    <= '0;
      opB    <= '0;
      ctrl   <= '0;
      beat   <= '0;
      result <= '0;
    end else if (accept) begin
      opA  <= in_operand1;
      opB  <= in_vector_scalar ? {VECTOR_SIZE{in_scalar}} : in_operand2;
      ctrl <= in_alu_control;
      beat <= '0;
    end else if (state == RUN) begin
      // Lanes past the last element only exist on the final beat.
      for (int l = 0; l < LANES; l++) begin
        if (int'(beat) * LANES + l < VECTOR_SIZE)
          result[(int'(beat) * LANES + l) * DATA_WIDTH +: DATA_WIDTH] <=
            aluOp(ctrl,
                  opA[(int'(beat) * LANES + l) * DATA_WIDTH +: DATA_WIDTH],
                  opB[(int'(beat) * LANES + l) * DATA_WIDTH +: DATA_WIDTH]);
      end
      beat <= lastBeat ? '0 : beat + 1'b1;
    end
  end

  assign out_result = result;

endmodule
